calc_arbiter: RTL and testbench
===============================

Name: calc_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 8-bit calculation unit (mux-select plus ripple-carry adder, clocked internal operand registers).
- Accepts operation requests from two requesters over valid/ready handshakes.
- Holds the granted operands stable on the calculation unit for its full pipeline latency, then captures the result and returns it tagged with the requester ID.
- Also generates the calculation unit's synchronous active-high reset.

Parameters:
- CALC_LAT, 2: cycles from operands driven on calc_* until calc_result is valid; legal range 1..15.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  8  requester 0 operand a
- req0_b  in  8  requester 0 operand b
- req0_sel  in  2  requester 0 select (00 a+b, 01 a+~b, 10 a+0, 11 a+FF)
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, req1_cin: same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_result  out  8  captured sum
- calc_a  out  8  to calculation unit a
- calc_b  out  8  to calculation unit b
- calc_select  out  2  to calculation unit select
- calc_cin  out  1  to calculation unit cin
- calc_rst  out  1  to calculation unit rst (active-high)
- calc_result  in  8  from calculation unit result
- busy  out  1  high in RUN or RESP
- op_count  out  CNT_W  completed responses, wraps to 0

Behaviour:
- Reset (rst low, asynchronous) clears the following:
  - state = IDLE; rr pointer = 0 (requester 0 favoured); cnt = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0.
  - calc_a/b/select/cin = 0; op_count = 0.
  - calc_rst = 1.
- calc_rst stays 1 for 2 clk cycles after rst deasserts, then 0. It is driven from a 2-stage register.
- Arbitration happens only in IDLE, and only after calc_rst has dropped. The grant is fixed combinationally this cycle:
  - Only one valid: that requester wins.
  - Both valid: the requester favoured by rr wins.
- reqN_ready = 1 only for the winner, only in IDLE; at most one ready is high per cycle.
- On transfer (valid & ready):
  - Register the operands onto calc_*.
  - Set rsp_id = winner; cnt = CALC_LAT; state = RUN.
  - Set rr to favour the other requester.
- A requester dropping valid without ready has no effect; its request is never latched.
- RUN:
  - calc_* are held constant.
  - cnt decrements each cycle.
  - In the cycle cnt == 1: rsp_result <= calc_result, rsp_valid <= 1, state = RESP.
- Latency: rsp_valid rises CALC_LAT+1 cycles after the accepting edge.
- RESP: rsp_valid and rsp_result are held until rsp_ready.
- On rsp_valid & rsp_ready:
  - rsp_valid <= 0, op_count += 1 (wraps), state = IDLE.
  - No new grant is issued in that same cycle.
- Minimum spacing between accepts is CALC_LAT+2 cycles when rsp_ready is tied high.
- calc_* keep the last operands in IDLE; they are not zeroed.
- Reset mid-operation (in RUN or RESP): the in-flight operation is discarded, no response is issued, and calc_rst is pulsed per the rules above.
- Carry-out is not produced; the result is an 8-bit modulo sum.

Test Plan:
- Reset release:
  - Stimulus: hold rst low 3 cycles, then raise; req0_valid held high throughout.
  - Required: calc_rst high until 2 cycles after release; req0_ready first high on the 3rd cycle after release; all outputs 0 before that.
- Single add:
  - Stimulus: req0 a=8'h3C b=8'h05 sel=00 cin=0, CALC_LAT=2.
  - Required: rsp_valid 3 cycles after accept; rsp_result=8'h41; rsp_id=0; op_count=1 after rsp_ready.
- Subtract:
  - Stimulus: req1 a=8'h10 b=8'h03 sel=01 cin=1.
  - Required: rsp_result=8'h0D; rsp_id=1.
- Contention:
  - Stimulus: both valid continuously from reset; req0 a=8'h00 sel=11 cin=0; req1 a=8'h7F sel=10 cin=1.
  - Required: grant order 0,1,0,1; results 8'hFF, 8'h80 alternating; never both ready high.
- Backpressure:
  - Stimulus: rsp_ready low 5 cycles during RESP.
  - Required: rsp_valid/rsp_result/rsp_id stable; busy=1; no readys asserted.
- Mid-operation reset:
  - Stimulus: assert rst one cycle into RUN.
  - Required: rsp_valid never rises for that operation; op_count unchanged at 0.

Source files
------------

// File: rtl/calc_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 8-bit calculation unit.
// It holds the granted operands for the unit's latency and returns the result tagged with the requester ID.
module calc_arbiter #(
    parameter int unsigned CALC_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [1:0]       req0_sel,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [1:0]       req1_sel,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic [7:0]       calc_a,
    output logic [7:0]       calc_b,
    output logic [1:0]       calc_select,
    output logic             calc_cin,
    output logic             calc_rst,
    input  logic [7:0]       calc_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int unsigned LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       rst_pipe;
    logic             rr, rr_nxt;
    logic [LAT_W-1:0] cnt, cnt_nxt;
    logic             rsp_valid_nxt, rsp_id_nxt, calc_cin_nxt, busy_nxt;
    logic [7:0]       rsp_result_nxt, calc_a_nxt, calc_b_nxt;
    logic [1:0]       calc_select_nxt;
    logic [CNT_W-1:0] op_count_nxt;
    logic             win, grant;

    assign calc_rst = rst_pipe[1];

    // The calculation unit stays in reset for two clocks after rst is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= 2'b11;
        else      rst_pipe <= {rst_pipe[0], 1'b0};
    end

    // rr = 0 favours requester 0 when both are valid
    assign win   = (req0_valid && req1_valid) ? rr : req1_valid;
    assign grant = (state == IDLE) && !calc_rst && (req0_valid || req1_valid);

    always_comb begin
        state_nxt       = state;
        rr_nxt          = rr;
        cnt_nxt         = cnt;
        rsp_valid_nxt   = rsp_valid;
        rsp_id_nxt      = rsp_id;
        rsp_result_nxt  = rsp_result;
        calc_a_nxt      = calc_a;
        calc_b_nxt      = calc_b;
        calc_select_nxt = calc_select;
        calc_cin_nxt    = calc_cin;
        op_count_nxt    = op_count;
        req0_ready      = grant && !win;
        req1_ready      = grant && win;

        case (state)
            IDLE: begin
                if (grant) begin
                    calc_a_nxt      = win ? req1_a   : req0_a;
                    calc_b_nxt      = win ? req1_b   : req0_b;
                    calc_select_nxt = win ? req1_sel : req0_sel;
                    calc_cin_nxt    = win ? req1_cin : req0_cin;
                    rsp_id_nxt      = win;
                    rr_nxt          = !win;
                    cnt_nxt         = LAT_W'(CALC_LAT);
                    state_nxt       = RUN;
                end
            end
            RUN: begin
                cnt_nxt = cnt - LAT_W'(1);
                if (cnt == LAT_W'(1)) begin
                    rsp_result_nxt = calc_result;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    op_count_nxt  = op_count + CNT_W'(1);
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            calc_a      <= '0;
            calc_b      <= '0;
            calc_select <= '0;
            calc_cin    <= 1'b0;
            op_count    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr          <= rr_nxt;
            cnt         <= cnt_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_id      <= rsp_id_nxt;
            rsp_result  <= rsp_result_nxt;
            calc_a      <= calc_a_nxt;
            calc_b      <= calc_b_nxt;
            calc_select <= calc_select_nxt;
            calc_cin    <= calc_cin_nxt;
            op_count    <= op_count_nxt;
            busy        <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter: a vector table, directed corner sequences and a randomized scoreboard phase.
module tb_calc_arbiter;
    localparam int unsigned CALC_LAT = 2;
    localparam int unsigned CNT_W    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0_valid = 1'b0, req0_ready, req0_cin = 1'b0;
    logic req1_valid = 1'b0, req1_ready, req1_cin = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_sel = '0, req1_sel = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic [7:0] rsp_result, calc_a, calc_b, calc_result;
    logic [1:0] calc_select;
    logic calc_cin, calc_rst, busy;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    calc_arbiter #(.CALC_LAT(CALC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .calc_a(calc_a), .calc_b(calc_b), .calc_select(calc_select), .calc_cin(calc_cin),
        .calc_rst(calc_rst), .calc_result(calc_result), .busy(busy), .op_count(op_count)
    );

    function automatic logic [7:0] calc_sum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] sel, input logic cin);
        logic [7:0] opb;
        case (sel)
            2'b00:   opb = b;
            2'b01:   opb = ~b;
            2'b10:   opb = 8'h00;
            default: opb = 8'hFF;
        endcase
        return 8'(a + opb + {7'd0, cin});
    endfunction

    // Calculation unit: registered operands feeding a combinational adder
    logic [7:0] cu_a, cu_b;
    logic [1:0] cu_sel;
    logic       cu_cin;
    always @(posedge clk) begin
        if (calc_rst) begin
            cu_a <= '0; cu_b <= '0; cu_sel <= '0; cu_cin <= 1'b0;
        end else begin
            cu_a <= calc_a; cu_b <= calc_b; cu_sel <= calc_select; cu_cin <= calc_cin;
        end
    end
    assign calc_result = calc_sum(cu_a, cu_b, cu_sel, cu_cin);

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
        logic       cin;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] res;
        int         acc_cyc;
    } exp_t;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_cnt = 0;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] sel, input logic cin);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; req0_cin = cin;
        end
    endtask

    // One single-requester transaction with rsp_ready high; rel adds reset-release checks
    task automatic run_op(input vec_t v, input bit rel);
        int   w;
        int   lat;
        logic rdy, other;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        drive_req(v.id, v.a, v.b, v.sel, v.cin);
        w = 0;
        forever begin
            @(negedge clk);
            w++;
            rdy   = v.id ? req1_ready : req0_ready;
            other = v.id ? req0_ready : req1_ready;
            chk("other_ready", 32'(other), 32'd0);
            if (rel) begin
                chk("rel_calc_rst", 32'(calc_rst), 32'(w < 3));
                chk("rel_ready", 32'(rdy), 32'(w >= 3));
            end
            if (rdy || w >= 30) break;
        end
        chk("accept", 32'(rdy), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        chk("latency", 32'(lat), 32'(CALC_LAT + 1));
        chk("rsp_id", 32'(rsp_id), 32'(v.id));
        chk("rsp_result", 32'(rsp_result), 32'(v.exp));
        chk("busy_resp", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        exp_cnt++;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(CNT_W'(exp_cnt)));
        chk("busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        exp_t q[$];
        exp_t e;
        logic fav, e0, e1, exp_rv;
        int   accepts, w, last_acc, nacc;
        logic rid[$];
        logic [7:0] rres[$];
        logic gid[$];

        tbl[0] = '{1'b0, 8'h3C, 8'h05, 2'b00, 1'b0, 8'h41};
        tbl[1] = '{1'b1, 8'h10, 8'h03, 2'b01, 1'b1, 8'h0D};
        tbl[2] = '{1'b0, 8'hFF, 8'h01, 2'b00, 1'b1, 8'h01};
        tbl[3] = '{1'b1, 8'h80, 8'h55, 2'b10, 1'b1, 8'h81};
        tbl[4] = '{1'b0, 8'h00, 8'hAA, 2'b11, 1'b0, 8'hFF};
        tbl[5] = '{1'b1, 8'h7F, 8'h00, 2'b11, 1'b1, 8'h7F};
        tbl[6] = '{1'b0, 8'hA5, 8'h5A, 2'b01, 1'b0, 8'h4A};

        // Reset release with req0 valid throughout, then the single add
        rst = 1'b0;
        drive_req(1'b0, tbl[0].a, tbl[0].b, tbl[0].sel, tbl[0].cin);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", {rsp_valid, rsp_id, rsp_result, calc_a, calc_b, calc_select,
                               calc_cin, busy, req0_ready, req1_ready}, 32'd0);
            chk("reset_op_count", 32'(op_count), 32'd0);
            chk("reset_calc_rst", 32'(calc_rst), 32'd1);
        end
        @(posedge clk); #1 rst = 1'b1;
        run_op(tbl[0], 1'b1);

        for (int i = 1; i < 7; i++) run_op(tbl[i], 1'b0);

        // Backpressure during RESP
        rsp_ready = 1'b0;
        drive_req(1'b0, 8'h21, 8'h12, 2'b00, 1'b0);
        w = 0;
        do begin @(negedge clk); w++; end while (!req0_ready && w < 30);
        chk("bp_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!rsp_valid && w < 40);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_req(1'b0, 8'h01, 8'h01, 2'b00, 1'b0);
            drive_req(1'b1, 8'h02, 8'h02, 2'b00, 1'b0);
            @(negedge clk);
            chk("bp_hold", {22'd0, rsp_valid, rsp_id, rsp_result}, {22'd0, 1'b1, 1'b0, 8'h33});
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_no_grant", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        exp_cnt++;
        chk("bp_op_count", 32'(op_count), 32'(CNT_W'(exp_cnt)));
        chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Contention from reset: both valid continuously
        rsp_ready = 1'b1;
        drive_req(1'b0, 8'h00, 8'h5A, 2'b11, 1'b0);
        drive_req(1'b1, 8'h7F, 8'hC3, 2'b10, 1'b1);
        do_reset(2);
        last_acc = -1;
        nacc = 0;
        for (int c = 0; c < 80 && rid.size() < 4; c++) begin
            @(negedge clk);
            chk("cont_one_ready", 32'(req0_ready && req1_ready), 32'd0);
            if (req0_ready || req1_ready) begin
                gid.push_back(req1_ready);
                if (last_acc >= 0) chk("cont_spacing", 32'(c - last_acc), 32'(CALC_LAT + 2));
                last_acc = c;
                nacc++;
            end
            if (rsp_valid && rsp_ready) begin
                rid.push_back(rsp_id);
                rres.push_back(rsp_result);
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_rsp_count", 32'(rid.size()), 32'd4);
        for (int k = 0; k < rid.size(); k++) begin
            chk("cont_grant", 32'(gid[k]), 32'(k % 2));
            chk("cont_rsp_id", 32'(rid[k]), 32'(k % 2));
            chk("cont_result", 32'(rres[k]), (k % 2 == 1) ? 32'h80 : 32'hFF);
        end

        // Randomized traffic against a transaction-level scoreboard
        do_reset(2);
        repeat (3) begin @(posedge clk); #1; end
        fav = 1'b0;
        accepts = 0;
        for (int c = 0; c < 600; c++) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 2'($urandom); req0_cin = 1'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 2'($urandom); req1_cin = 1'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            e0 = (q.size() == 0) && req0_valid && (!req1_valid || !fav);
            e1 = (q.size() == 0) && req1_valid && (!req0_valid || fav);
            chk("rnd_ready0", 32'(req0_ready), 32'(e0));
            chk("rnd_ready1", 32'(req1_ready), 32'(e1));
            chk("rnd_op_count", 32'(op_count), 32'(CNT_W'(exp_cnt)));
            exp_rv = (q.size() != 0) && ((c - q[0].acc_cyc) >= int'(CALC_LAT) + 1);
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (q.size() != 0 && rsp_valid && rsp_ready) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rnd_result", 32'(rsp_result), 32'(q[0].res));
                void'(q.pop_front());
                exp_cnt++;
            end
            if (req0_valid && req0_ready) begin
                e.id = 1'b0; e.res = calc_sum(req0_a, req0_b, req0_sel, req0_cin); e.acc_cyc = c;
                q.push_back(e); fav = 1'b1; accepts++;
            end else if (req1_valid && req1_ready) begin
                e.id = 1'b1; e.res = calc_sum(req1_a, req1_b, req1_sel, req1_cin); e.acc_cyc = c;
                q.push_back(e); fav = 1'b0; accepts++;
            end
            @(posedge clk); #1;
        end
        chk("rnd_progress", 32'(accepts > 20), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;

        // Reset one cycle into RUN discards the operation
        do_reset(2);
        repeat (3) begin @(posedge clk); #1; end
        drive_req(1'b0, 8'h11, 8'h22, 2'b00, 1'b0);
        w = 0;
        do begin @(negedge clk); w++; end while (!req0_ready && w < 30);
        chk("mid_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy_run", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_reset_outs", {29'd0, rsp_valid, busy, calc_rst}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid_op_count", 32'(op_count), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
